// File: rtl/mips_pkg.sv
// Shared constants for the pipelined MIPS core: result-source and load-type
// encodings plus the default datapath width.
package mips_pkg;

  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_BU = 3'b010;
  localparam logic [2:0] LD_H  = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

endpackage

// File: rtl/load_extend.sv
// Sub-word load lane select with sign/zero extension; purely combinational so
// the MEM stage can reuse it.
module load_extend
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] read_data,
  input  logic [2:0]        load_type,
  input  logic [1:0]        byte_off,
  output logic [DATA_W-1:0] load_data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Half lane uses only the upper offset bit; odd half addresses round down.
  assign byte_c = read_data[{byte_off, 3'b000} +: 8];
  assign half_c = read_data[{byte_off[1], 4'b0000} +: 16];

  always_comb begin
    load_data_c = read_data;
    unique case (load_type)
      LD_B:    load_data_c = {{(DATA_W-8){byte_c[7]}}, byte_c};
      LD_BU:   load_data_c = {{(DATA_W-8){1'b0}}, byte_c};
      LD_H:    load_data_c = {{(DATA_W-16){half_c[15]}}, half_c};
      LD_HU:   load_data_c = {{(DATA_W-16){1'b0}}, half_c};
      default: load_data_c = read_data;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with result selection, load extraction ahead of the
// register, register-file write port and a retired-instruction counter.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned REG_AW   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  input  logic              m_reg_write,
  input  logic [1:0]        m_result_src,
  input  logic [2:0]        m_load_type,
  input  logic [1:0]        m_byte_off,
  input  logic [DATA_W-1:0] m_alu_res,
  input  logic [DATA_W-1:0] m_read_data,
  input  logic [DATA_W-1:0] m_pc_plus4,
  input  logic [DATA_W-1:0] m_imm,
  input  logic [REG_AW-1:0] m_des_reg,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_des_reg,
  output logic [DATA_W-1:0] wb_write_data,
  output logic [CNT_W-1:0]  retired
);

  logic              valid_q,      valid_d;
  logic              reg_write_q,  reg_write_d;
  logic [REG_AW-1:0] des_reg_q,    des_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [CNT_W-1:0]  retired_q,    retired_d;

  logic [DATA_W-1:0] load_data_c;
  logic [DATA_W-1:0] result_c;
  logic              zero_dest_c;
  logic              load_c;

  load_extend #(
    .DATA_W (DATA_W)
  ) u_load_extend (
    .read_data   (m_read_data),
    .load_type   (m_load_type),
    .byte_off    (m_byte_off),
    .load_data_c (load_data_c)
  );

  // Result source select, resolved before the register.
  always_comb begin
    result_c = m_alu_res;
    unique case (m_result_src)
      RES_ALU: result_c = m_alu_res;
      RES_MEM: result_c = load_data_c;
      RES_PC4: result_c = m_pc_plus4;
      RES_IMM: result_c = m_imm;
      default: result_c = m_alu_res;
    endcase
  end

  assign zero_dest_c = ZERO_REG && (m_des_reg == '0);
  assign load_c      = !flush && !stall;

  // Next state: flush beats stall beats load; bubbles drive zeros.
  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    des_reg_d    = des_reg_q;
    write_data_d = write_data_q;
    retired_d    = retired_q;
    if (flush) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      des_reg_d    = '0;
      write_data_d = '0;
    end else if (load_c) begin
      valid_d      = m_valid;
      reg_write_d  = m_valid && m_reg_write && !zero_dest_c;
      des_reg_d    = m_valid ? m_des_reg : '0;
      write_data_d = m_valid ? result_c  : '0;
      if (m_valid) begin
        retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      des_reg_q    <= '0;
      write_data_q <= '0;
      retired_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      des_reg_q    <= des_reg_d;
      write_data_q <= write_data_d;
      retired_q    <= retired_d;
    end
  end

  assign wb_valid      = valid_q;
  assign wb_reg_write  = reg_write_q;
  assign wb_des_reg    = des_reg_q;
  assign wb_write_data = write_data_q;
  assign retired       = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed vectors push expected WB
// contents; a monitor pops and compares one cycle later.
module tb_writeback_stage;
  import mips_pkg::*;

  typedef struct {
    logic        valid;
    logic        we;
    logic [4:0]  des;
    logic [31:0] data;
    logic [31:0] ret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid, m_reg_write, stall, flush;
  logic [1:0]  m_result_src, m_byte_off;
  logic [2:0]  m_load_type;
  logic [31:0] m_alu_res, m_read_data, m_pc_plus4, m_imm;
  logic [4:0]  m_des_reg;
  logic        wb_valid, wb_reg_write, wb_valid4, wb_reg_write4;
  logic [4:0]  wb_des_reg, wb_des_reg4;
  logic [31:0] wb_write_data, wb_write_data4, retired;
  logic [3:0]  retired4;

  exp_t        sb_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_ret = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_reg_write(m_reg_write),
    .m_result_src(m_result_src), .m_load_type(m_load_type), .m_byte_off(m_byte_off),
    .m_alu_res(m_alu_res), .m_read_data(m_read_data), .m_pc_plus4(m_pc_plus4),
    .m_imm(m_imm), .m_des_reg(m_des_reg), .stall(stall), .flush(flush),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_des_reg(wb_des_reg),
    .wb_write_data(wb_write_data), .retired(retired)
  );

  // Narrow-counter copy on the same stimulus to exercise wrap-around.
  writeback_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .m_reg_write(m_reg_write),
    .m_result_src(m_result_src), .m_load_type(m_load_type), .m_byte_off(m_byte_off),
    .m_alu_res(m_alu_res), .m_read_data(m_read_data), .m_pc_plus4(m_pc_plus4),
    .m_imm(m_imm), .m_des_reg(m_des_reg), .stall(stall), .flush(flush),
    .wb_valid(wb_valid4), .wb_reg_write(wb_reg_write4), .wb_des_reg(wb_des_reg4),
    .wb_write_data(wb_write_data4), .retired(retired4)
  );

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
  endfunction

  function automatic void check_all(input string tag, input exp_t e);
    check({tag, ".wb_valid"},      32'(wb_valid),     32'(e.valid));
    check({tag, ".wb_reg_write"},  32'(wb_reg_write), 32'(e.we));
    check({tag, ".wb_des_reg"},    32'(wb_des_reg),   32'(e.des));
    check({tag, ".wb_write_data"}, wb_write_data,     e.data);
    check({tag, ".retired"},       retired,           e.ret);
    check({tag, ".retired4"},      32'(retired4),     32'(e.ret[3:0]));
  endfunction

  // Monitor: one output sample per clock, just after the active edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) check_all("sb", sb_q.pop_front());
    end
  end

  task automatic set_in(input logic v, input logic rw, input logic [1:0] src,
                        input logic [2:0] lt, input logic [1:0] off,
                        input logic [31:0] val, input logic [4:0] des);
    m_valid = v; m_reg_write = rw; m_result_src = src; m_load_type = lt;
    m_byte_off = off; m_des_reg = des;
    m_alu_res = val; m_pc_plus4 = val; m_imm = val;
  endtask

  // Caller sets inputs at a falling edge; expected retire count follows the
  // load rule (valid, no stall, no flush).
  task automatic step(input logic ev, input logic ewe, input logic [4:0] ed,
                      input logic [31:0] edata);
    exp_t e;
    if (!flush && !stall && m_valid) exp_ret = exp_ret + 1;
    e.valid = ev; e.we = ewe; e.des = ed; e.data = edata; e.ret = exp_ret;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    exp_t z;
    z.valid = 0; z.we = 0; z.des = 0; z.data = 0; z.ret = 0;
    #3 rst_n = 1'b0;
    #1 check_all(tag, z);
    @(negedge clk);
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    exp_ret = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    m_read_data = 32'h80FF_7F01;
    set_in(0, 0, RES_ALU, LD_W, 0, 0, 0);
    @(negedge clk);
    async_reset_check("reset0");
    step(0, 0, 0, 0);

    // Result sources
    set_in(1, 1, RES_ALU, LD_W, 0, 32'h1234_5678, 5);  step(1, 1, 5, 32'h1234_5678);
    set_in(1, 1, RES_PC4, LD_W, 0, 32'h0040_0010, 31); step(1, 1, 31, 32'h0040_0010);
    set_in(1, 1, RES_IMM, LD_W, 0, 32'hABCD_0000, 2);  step(1, 1, 2, 32'hABCD_0000);

    // Loads from 0x80FF_7F01
    set_in(1, 1, RES_MEM, LD_B,   3, 32'h5555_5555, 6);  step(1, 1, 6,  32'hFFFF_FF80);
    set_in(1, 1, RES_MEM, LD_BU,  2, 32'h5555_5555, 7);  step(1, 1, 7,  32'h0000_00FF);
    set_in(1, 1, RES_MEM, LD_H,   2, 32'h5555_5555, 8);  step(1, 1, 8,  32'hFFFF_80FF);
    set_in(1, 1, RES_MEM, LD_HU,  0, 32'h5555_5555, 9);  step(1, 1, 9,  32'h0000_7F01);
    set_in(1, 1, RES_MEM, LD_B,   1, 32'h5555_5555, 10); step(1, 1, 10, 32'h0000_007F);
    set_in(1, 1, RES_MEM, LD_H,   3, 32'h5555_5555, 11); step(1, 1, 11, 32'hFFFF_80FF);
    set_in(1, 1, RES_MEM, LD_W,   1, 32'h5555_5555, 12); step(1, 1, 12, 32'h80FF_7F01);
    set_in(1, 1, RES_MEM, 3'b111, 2, 32'h5555_5555, 13); step(1, 1, 13, 32'h80FF_7F01);

    // Zero register, non-writing instruction, bubble
    set_in(1, 1, RES_ALU, LD_W, 0, 32'hDEAD_BEEF, 0); step(1, 0, 0, 32'hDEAD_BEEF);
    set_in(1, 0, RES_ALU, LD_W, 0, 32'h0000_0042, 3); step(1, 0, 3, 32'h0000_0042);
    set_in(0, 1, RES_ALU, LD_W, 0, 32'hFFFF_FFFF, 4); step(0, 0, 0, 32'h0);

    // Stall holds for three cycles, then stall+flush and flush alone bubble
    set_in(1, 1, RES_ALU, LD_W, 0, 32'hCAFE_F00D, 17); step(1, 1, 17, 32'hCAFE_F00D);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, RES_IMM, LD_W, 0, 32'h1111_0000 + 32'(i), 5'(20 + i));
      step(1, 1, 17, 32'hCAFE_F00D);
    end
    flush = 1'b1;
    set_in(1, 1, RES_ALU, LD_W, 0, 32'h7777_7777, 21); step(0, 0, 0, 32'h0);
    stall = 1'b0;
    set_in(1, 1, RES_ALU, LD_W, 0, 32'h8888_8888, 22); step(0, 0, 0, 32'h0);
    flush = 1'b0;
    set_in(1, 1, RES_ALU, LD_W, 0, 32'h9999_9999, 23); step(1, 1, 23, 32'h9999_9999);

    // Reset asserted while stalled clears everything without a clock edge
    stall = 1'b1;
    async_reset_check("reset_stall");
    set_in(0, 0, RES_ALU, LD_W, 0, 0, 0);
    step(0, 0, 0, 0);

    // Seventeen retirements: 32-bit counter reads 17, 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) begin
      set_in(1, 1, RES_ALU, LD_W, 0, 32'(i * 3 + 1), 1);
      step(1, 1, 1, 32'(i * 3 + 1));
    end
    set_in(0, 0, RES_ALU, LD_W, 0, 0, 0);
    step(0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
